// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the data-memory access unit.
package mem_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W_DEFAULT   = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Halfwords need an even address; words (and size 11) need a 4-byte boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Little-endian lane steering: byte enables and replicated store data out,
// lane-selected and extended load data back.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_rep_c,
  output logic [31:0] rdata_fmt_c
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be_c        = 4'b1111;
    wdata_rep_c = wdata;
    rdata_fmt_c = bus_rdata;
    rbyte       = bus_rdata[{addr_lo, 3'b000} +: 8];
    rhalf       = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size)
      SZ_BYTE: begin
        be_c        = 4'b0001 << addr_lo;
        wdata_rep_c = {4{wdata[7:0]}};
        rdata_fmt_c = {{24{sign_ext & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = {2{wdata[15:0]}};
        rdata_fmt_c = {{16{sign_ext & rhalf[15]}}, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Turns single-cycle datapath loads/stores into req/ack bus transactions,
// stalling the datapath until the access completes or times out.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        adel,
  output logic        ades,
  output logic        buserr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             req_d, we_d, buserr_d;
  logic [31:0]      addr_d, wd_d, rdata_d;
  logic [3:0]       be_d;
  logic             mis_c;
  logic [3:0]       be_c;
  logic [31:0]      wrep_c, rfmt_c;

  mem_lane_fmt u_lane_fmt (
    .size        (size),
    .sign_ext    (sign_ext),
    .addr_lo     (addr[1:0]),
    .wdata       (wdata),
    .bus_rdata   (bus_rdata),
    .be_c        (be_c),
    .wdata_rep_c (wrep_c),
    .rdata_fmt_c (rfmt_c)
  );

  // Exceptions and stall are gated by reset so the datapath sees all-zero while held.
  assign mis_c   = misaligned(size, addr[1:0]);
  assign adel    = rst & memen & mis_c & ~memwrite;
  assign ades    = rst & memen & mis_c & memwrite;
  assign stall   = rst & memen & ~mis_c & (state_q != ST_DONE);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = bus_req;
    we_d     = bus_we;
    addr_d   = bus_addr;
    be_d     = bus_be;
    wd_d     = bus_wdata;
    rdata_d  = rdata;
    buserr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memen && !mis_c) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = memwrite;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = be_c;
          wd_d    = wrep_c;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          if (!bus_we) rdata_d = rfmt_c;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d  = ST_DONE;
          req_d    = 1'b0;
          rdata_d  = '0;
          buserr_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      buserr    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_req   <= req_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_be    <= be_d;
      bus_wdata <= wd_d;
      rdata     <= rdata_d;
      buserr    <= buserr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random accesses
// compared against a transaction-level model of the expected bus/datapath behaviour.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk, rst;
  logic        memen, memwrite, sign_ext, bus_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, adel, ades, buserr, bus_req, bus_we;
  logic [3:0]  bus_be;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .memen     (memen),
    .memwrite  (memwrite),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .adel      (adel),
    .ades      (ades),
    .buserr    (buserr),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                             input logic [1:0] lo, input logic [31:0] w);
    int          nb;
    logic [31:0] m, v;
    nb = nbytes(sz);
    if (nb == 4) return w;
    m = (32'h1 << (8 * nb)) - 32'h1;
    v = (w >> (8 * int'(lo))) & m;
    if (sx && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  // One datapath instruction; ack_dly = WAIT cycles without ack before the ack (>= TO: none).
  task automatic do_access(input logic we, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int ack_dly);
    int          nb, k, nwait;
    logic        mis, acked;
    logic [3:0]  ebe;
    logic [31:0] ewd, m4;
    nb  = nbytes(sz);
    k   = int'(a[1:0]);
    mis = (k % nb) != 0;
    m4  = (32'h1 << nb) - 32'h1;
    ebe = 4'(m4 << (k - (k % nb)));
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
    acked = ack_dly < int'(TO);
    nwait = acked ? ack_dly + 1 : int'(TO);

    cyc();
    memen = 1'b1; memwrite = we; size = sz; sign_ext = sx; addr = a; wdata = wd;
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    #2;
    if (mis) begin
      check("adel_mis", adel, !we);
      check("ades_mis", ades, we);
      check("stall_mis", stall, 0);
      cyc();
      memen = 1'b0; bus_ack = 1'b0;
      #2;
      check("req_after_mis", bus_req, 0);
      return;
    end
    check("adel", adel, 0);
    check("ades", ades, 0);
    check("stall_accept", stall, 1);
    check("req_accept", bus_req, 0);
    check("buserr_accept", buserr, 0);

    for (int i = 1; i <= nwait; i++) begin
      cyc();
      bus_ack   = acked && (i == nwait);
      bus_rdata = (acked && i == nwait) ? rd : $urandom;
      #2;
      check("wait_req", bus_req, 1);
      check("wait_we", bus_we, we);
      check("wait_addr", bus_addr, {a[31:2], 2'b00});
      check("wait_be", bus_be, ebe);
      check("wait_wdata", bus_wdata, ewd);
      check("wait_stall", stall, 1);
      check("wait_rdata_hold", rdata, exp_rdata);
    end

    if (!acked) exp_rdata = 32'h0;
    else if (!we) exp_rdata = model_load(sz, sx, a[1:0], rd);

    cyc();
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    #2;
    check("done_stall", stall, 0);
    check("done_req", bus_req, 0);
    check("done_buserr", buserr, !acked);
    check("done_rdata", rdata, exp_rdata);

    cyc();
    memen = 1'b0; bus_ack = 1'($urandom); bus_rdata = $urandom;
    #2;
    check("idle_buserr", buserr, 0);
    check("idle_stall", stall, 0);
    check("idle_req", bus_req, 0);
    check("idle_rdata", rdata, exp_rdata);
  endtask

  initial begin
    rst = 1'b0; memen = 1'b0; memwrite = 1'b0; size = 2'b10; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    exp_rdata = 32'h0;
    repeat (3) cyc();
    memen = 1'b1; addr = 32'h100;
    #1;
    check("rst_stall", stall, 0);
    addr = 32'h101;
    #1;
    check("rst_adel", adel, 0);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_buserr", buserr, 0);
    memen = 1'b0;
    cyc();
    rst = 1'b1;

    // Directed cases from the intended use
    do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233, 0);
    do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233, 1);
    do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 3);
    do_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0);
    do_access(1'b1, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0);
    do_access(1'b0, 2'b01, 1'b1, 32'h206, 32'h0, 32'h8001F00D, 2);
    do_access(1'b0, 2'b11, 1'b0, 32'h300, 32'h0, 32'h12345678, 0);
    do_access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h55555555, 10);
    do_access(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'hCAFEF00D, int'(TO) - 1);

    // Reset in the middle of a WAIT
    cyc();
    memen = 1'b1; memwrite = 1'b0; size = 2'b10; addr = 32'h500; bus_ack = 1'b0;
    cyc();
    cyc();
    #2;
    check("pre_rst_req", bus_req, 1);
    rst = 1'b0;
    #1;
    check("rstw_req", bus_req, 0);
    check("rstw_stall", stall, 0);
    check("rstw_rdata", rdata, 0);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
    cyc();
    #2;
    check("rstw_req_ack", bus_req, 0);
    cyc();
    rst = 1'b1; memen = 1'b0;
    #2;
    check("post_rst_req", bus_req, 0);
    check("post_rst_stall", stall, 0);
    check("post_rst_buserr", buserr, 0);
    exp_rdata = 32'h0;
    cyc();
    bus_ack = 1'b0;
    #2;
    check("late_ack_req", bus_req, 0);
    check("late_ack_rdata", rdata, 0);
    do_access(1'b0, 2'b00, 1'b1, 32'h501, 32'h0, 32'h0000F100, 0);

    // Random accesses
    for (int n = 0; n < 150; n++) begin
      do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom, int'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the single-cycle datapath, on the data-memory side.
- Consumes the datapath's ALU address and store data, and returns read data and a stall.
- Converts each single-cycle load/store into a request/acknowledge bus transaction with byte/halfword lane handling, alignment checking and a bus timeout.
- The datapath holds its PC and register writes while stall=1.

Parameters:
- TIMEOUT, 255: WAIT cycles without bus_ack before bus error is declared.
- CNT_W, 8: width of timeout counter; TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- memen  in  1  datapath requests a memory access this instruction.
- memwrite  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rt), right-justified.
- rdata  out  32  formatted load data to the datapath result mux.
- stall  out  1  hold datapath.
- adel  out  1  misaligned load, combinational.
- ades  out  1  misaligned store, combinational.
- buserr  out  1  one-cycle pulse on timeout.
- bus_req  out  1  registered request.
- bus_we  out  1  registered write enable.
- bus_addr  out  32  registered, {addr[31:2],2'b00}.
- bus_be  out  4  registered byte enables, lane i = bits [8i+7:8i].
- bus_wdata  out  32  registered, lane-replicated store data.
- bus_ack  in  1  completion; read data valid the same cycle.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, all outputs 0; an in-flight bus_req drops immediately. Any late ack after release is ignored.
- Alignment: misaligned = (size==01 & addr[0]) | (size[1] & addr[1:0]!=0).
  - If memen and misaligned: adel=~memwrite, ades=memwrite, no bus cycle, stall=0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on memen & aligned, register the bus outputs (bus_req=1, bus_we=memwrite) and go to WAIT.
  - WAIT: bus outputs held stable; counter increments each cycle.
    - bus_ack=1: capture formatted load data into rdata (stores: rdata unchanged), drop bus_req, go to DONE.
    - Counter reaches TIMEOUT with no ack: drop bus_req, rdata=0, buserr=1 for one cycle, go to DONE.
    - Ack in the same cycle as timeout: ack wins, no buserr.
  - DONE: one cycle, then go to IDLE and clear the counter.
- stall = memen & aligned & (state != DONE), combinational.
  - Minimum access: 3 cycles (accept, WAIT with ack, DONE); stall is high for the first 2.
- bus_ack outside WAIT is ignored.
- Little-endian lanes, k = addr[1:0]:
  - Byte: bus_be = 4'b0001<<k; bus_wdata = {4{wdata[7:0]}}.
  - Half: bus_be = k[1] ? 1100 : 0011; bus_wdata = {2{wdata[15:0]}}.
  - Word: bus_be = 1111; bus_wdata = wdata.
  - Loads select lane k (byte) or halfword k[1], then extend per sign_ext; word loads are passed through.
- rdata holds its last value until the next completed load.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encodings.
  - Default TIMEOUT constant.
- One combinational sub-module, mem_lane_fmt:
  - Inputs: size, sign_ext, addr[1:0], wdata, bus_rdata.
  - Outputs: bus_be, lane-replicated write data, formatted load data.
  - Shared by the store and load paths; the FSM and counter stay in the top.

Test Plan:
- Word load, addr=0x100, memen=1, ack in first WAIT cycle, bus_rdata=0xDEADBEEF
  -> bus_addr=0x100, bus_be=1111, stall high 2 cycles, rdata=0xDEADBEEF in DONE.
- Byte signed load, addr=0x103, bus_rdata=0x80112233, sign_ext=1
  -> rdata=0xFFFFFF80; same with sign_ext=0 -> 0x00000080.
- Half store, addr=0x202, wdata=0x0000ABCD, ack after 3 wait cycles
  -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, outputs stable until ack, stall high 5 cycles.
- Misaligned word load, addr=0x101
  -> adel=1, ades=0, bus_req never rises, stall=0; same as a store -> ades=1.
- No ack, TIMEOUT=4
  -> buserr pulses once after 4 WAIT cycles, rdata=0, next cycle DONE, stall drops; ack with timeout in the same cycle -> no buserr.
- rst low during WAIT
  -> bus_req=0 and stall=0 immediately, state IDLE; ack during reset is ignored; a new access after release completes normally.
